btn_event_arbiter: RTL and testbench

BTN_EVENT_ARBITER -- requirements
Module: btn_event_arbiter

---
 rtl/btn_arb_pkg.sv | 10 +
 rtl/btn_hold_timer.sv | 38 +++
 rtl/btn_event_arbiter.sv | 156 +++++++++++++++
 tb/tb_btn_event_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_arb_pkg.sv
// Shared event-type encoding for the button event arbiter.
package btn_arb_pkg;

    typedef enum logic [1:0] {
        EVT_PRESS   = 2'b00,
        EVT_RELEASE = 2'b01,
        EVT_LONG    = 2'b10
    } evt_type_e;

endpackage

// File: rtl/btn_hold_timer.sv
// Per-button hold counter: fires once per press on the cycle the counter sits at HOLD_CYCLES-1.
module btn_hold_timer #(
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic level_i,
    output logic fire_o
);

    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(HOLD_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // One step past HOLD_CYCLES-1 parks the counter, so the fire condition cannot repeat.
    always_comb begin
        cnt_d = cnt_q;
        if (!level_i) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign fire_o = level_i && (cnt_q == CNT_LAST);

    // NOTE: sequential state uses non-blocking assignments only; next-state math lives in always_comb.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/btn_event_arbiter.sv
// Round-robin arbiter turning per-button press/release (and optional long-press) pulses into one event stream.
// Long-press detection is built only when BTN_ARB_LONGPRESS_EN is defined.
module btn_event_arbiter
    import btn_arb_pkg::*;
#(
    parameter int N_BTN       = 4,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_BTN-1:0]         p_edge,
    input  logic [N_BTN-1:0]         n_edge,
    input  logic [N_BTN-1:0]         debounced,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [$clog2(N_BTN)-1:0] evt_id,
    output logic [1:0]               evt_type,
    output logic                     pending_any,
    output logic                     overflow,
    input  logic                     ovf_clr
);

    localparam int ID_W = $clog2(N_BTN);

    logic [N_BTN-1:0] press_pend_q, press_pend_d;
    logic [N_BTN-1:0] rel_pend_q, rel_pend_d;
    logic [N_BTN-1:0] long_pend;
    logic [N_BTN-1:0] clr_press, clr_long, clr_rel, any_pend;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d, sel_id, cand;
    logic             found, load;
    evt_type_e        sel_type;
    logic             evt_valid_q, evt_valid_d;
    logic [ID_W-1:0]  evt_id_q, evt_id_d;
    evt_type_e        evt_type_q, evt_type_d;
    logic             overflow_q, overflow_d;
    logic             drop_short, drop_long;

    // Arbitration and output-register load decision.
    always_comb begin
        load     = !evt_valid_q || evt_ready;
        any_pend = press_pend_q | long_pend | rel_pend_q;
        found    = 1'b0;
        sel_id   = '0;
        cand     = '0;
        for (int k = 0; k < N_BTN; k++) begin
            cand = ID_W'((int'(rr_ptr_q) + k) % N_BTN);
            if (!found && any_pend[cand]) begin
                found  = 1'b1;
                sel_id = cand;
            end
        end

        if (press_pend_q[sel_id]) begin
            sel_type = EVT_PRESS;
        end else if (long_pend[sel_id]) begin
            sel_type = EVT_LONG;
        end else begin
            sel_type = EVT_RELEASE;
        end

        clr_press   = '0;
        clr_long    = '0;
        clr_rel     = '0;
        evt_valid_d = evt_valid_q;
        evt_id_d    = evt_id_q;
        evt_type_d  = evt_type_q;
        rr_ptr_d    = rr_ptr_q;
        if (load) begin
            evt_valid_d = found;
            if (found) begin
                evt_id_d   = sel_id;
                evt_type_d = sel_type;
                rr_ptr_d   = (sel_id == ID_W'(N_BTN - 1)) ? '0 : sel_id + 1'b1;
                case (sel_type)
                    EVT_PRESS: clr_press[sel_id] = 1'b1;
                    EVT_LONG:  clr_long[sel_id]  = 1'b1;
                    default:   clr_rel[sel_id]   = 1'b1;
                endcase
            end
        end
    end

    // A new edge beats a same-cycle clear; it is only lost when the flag stays set.
    always_comb begin
        press_pend_d = (press_pend_q & ~clr_press) | p_edge;
        rel_pend_d   = (rel_pend_q & ~clr_rel) | n_edge;
        drop_short   = |((press_pend_q & ~clr_press & p_edge) | (rel_pend_q & ~clr_rel & n_edge));
        if (drop_short || drop_long) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

`ifdef BTN_ARB_LONGPRESS_EN
    logic [N_BTN-1:0] long_pend_q, long_pend_d, long_fire;

    for (genvar g = 0; g < N_BTN; g++) begin : g_hold
        btn_hold_timer #(
            .HOLD_CYCLES (HOLD_CYCLES)
        ) u_hold_timer (
            .clk     (clk),
            .rst     (rst),
            .level_i (debounced[g]),
            .fire_o  (long_fire[g])
        );
    end

    assign long_pend_d = (long_pend_q & ~clr_long) | long_fire;
    assign drop_long   = |(long_pend_q & ~clr_long & long_fire);
    assign long_pend   = long_pend_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            long_pend_q <= '0;
        end else begin
            long_pend_q <= long_pend_d;
        end
    end
`else
    logic unused_cfg;

    assign long_pend  = '0;
    assign drop_long  = 1'b0;
    assign unused_cfg = &{1'b0, debounced, clr_long, HOLD_CYCLES > 1};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            press_pend_q <= '0;
            rel_pend_q   <= '0;
            rr_ptr_q     <= '0;
            evt_valid_q  <= 1'b0;
            evt_id_q     <= '0;
            evt_type_q   <= EVT_PRESS;
            overflow_q   <= 1'b0;
        end else begin
            press_pend_q <= press_pend_d;
            rel_pend_q   <= rel_pend_d;
            rr_ptr_q     <= rr_ptr_d;
            evt_valid_q  <= evt_valid_d;
            evt_id_q     <= evt_id_d;
            evt_type_q   <= evt_type_d;
            overflow_q   <= overflow_d;
        end
    end

    assign evt_valid   = evt_valid_q;
    assign evt_id      = evt_id_q;
    assign evt_type    = evt_type_q;
    assign pending_any = |any_pend;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Directed-vector bench for btn_event_arbiter (N_BTN=4, HOLD_CYCLES=20).
module tb_btn_event_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] p_edge, n_edge, debounced;
    logic       evt_ready, ovf_clr;
    logic       evt_valid, pending_any, overflow;
    logic [1:0] evt_id, evt_type;

    int vectors     = 0;
    int miscompares = 0;

`ifdef BTN_ARB_LONGPRESS_EN
    localparam int EXP_LONG_25 = 1;
`else
    localparam int EXP_LONG_25 = 0;
`endif

    btn_event_arbiter #(
        .N_BTN       (4),
        .HOLD_CYCLES (20)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .p_edge      (p_edge),
        .n_edge      (n_edge),
        .debounced   (debounced),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_id      (evt_id),
        .evt_type    (evt_type),
        .pending_any (pending_any),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst       = 1'b1;
        p_edge    = '0;
        n_edge    = '0;
        debounced = '0;
        ovf_clr   = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        p_edge    = 4'b1111;
        n_edge    = 4'b1111;
        debounced = '0;
        evt_ready = 1'b1;
        ovf_clr   = 1'b0;
        tick();
        tick();
        vectors++;
        if ({evt_valid, evt_id, evt_type} !== 5'b0_00_00) begin
            miscompares++;
            $display("FAIL reset_evt: got v=%b id=%0d t=%b, want v=0 id=0 t=00", evt_valid, evt_id, evt_type);
        end
        vectors++;
        if ({pending_any, overflow} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_status: got pend=%b ovf=%b, want 0 0", pending_any, overflow);
        end
        rst    = 1'b0;
        p_edge = '0;
        n_edge = '0;
    endtask

    task automatic test_single_press;
        apply_reset();
        evt_ready = 1'b1;
        p_edge    = 4'b0100;
        tick();
        p_edge = '0;
        vectors++;
        if ({evt_valid, pending_any} !== 2'b01) begin
            miscompares++;
            $display("FAIL single_c1: got v=%b pend=%b, want v=0 pend=1", evt_valid, pending_any);
        end
        tick();
        vectors++;
        if ({evt_valid, evt_id, evt_type} !== 5'b1_10_00) begin
            miscompares++;
            $display("FAIL single_c2: got v=%b id=%0d t=%b, want v=1 id=2 t=00", evt_valid, evt_id, evt_type);
        end
        tick();
        vectors++;
        if ({evt_valid, pending_any} !== 2'b00) begin
            miscompares++;
            $display("FAIL single_c3: got v=%b pend=%b, want v=0 pend=0", evt_valid, pending_any);
        end
    endtask

    task automatic test_round_robin;
        logic [1:0] exp_a [3] = '{2'd0, 2'd1, 2'd3};
        logic [1:0] exp_b [2] = '{2'd0, 2'd1};
        apply_reset();
        evt_ready = 1'b1;
        p_edge    = 4'b1011;
        tick();
        p_edge = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({evt_valid, evt_id, evt_type} !== {1'b1, exp_a[i], 2'b00}) begin
                miscompares++;
                $display("FAIL rr_a%0d: got v=%b id=%0d t=%b, want v=1 id=%0d t=00", i, evt_valid, evt_id, evt_type, exp_a[i]);
            end
        end
        tick();
        vectors++;
        if (evt_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rr_a_idle: got v=%b, want 0", evt_valid);
        end
        p_edge = 4'b0011;
        tick();
        p_edge = '0;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if ({evt_valid, evt_id, evt_type} !== {1'b1, exp_b[i], 2'b00}) begin
                miscompares++;
                $display("FAIL rr_b%0d: got v=%b id=%0d t=%b, want v=1 id=%0d t=00", i, evt_valid, evt_id, evt_type, exp_b[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        apply_reset();
        evt_ready = 1'b1;
        p_edge    = 4'b0001;
        tick();
        tick();
        p_edge = '0;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if ({evt_valid, evt_id, evt_type} !== 5'b1_00_00) begin
                miscompares++;
                $display("FAIL b2b_%0d: got v=%b id=%0d t=%b, want v=1 id=0 t=00", i, evt_valid, evt_id, evt_type);
            end
            tick();
        end
        vectors++;
        if ({evt_valid, overflow} !== 2'b00) begin
            miscompares++;
            $display("FAIL b2b_end: got v=%b ovf=%b, want v=0 ovf=0", evt_valid, overflow);
        end
    endtask

    task automatic test_backpressure;
        logic [2:0] exp_ovf [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        apply_reset();
        evt_ready = 1'b0;
        p_edge    = 4'b0001;
        tick();
        p_edge = '0;
        tick();
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if ({evt_valid, evt_id, evt_type, overflow} !== {5'b1_00_00, exp_ovf[i][0]}) begin
                miscompares++;
                $display("FAIL bp_hold%0d: got v=%b id=%0d t=%b ovf=%b, want v=1 id=0 t=00 ovf=%b",
                         i, evt_valid, evt_id, evt_type, overflow, exp_ovf[i][0]);
            end
            p_edge = (i == 0 || i == 2) ? 4'b0001 : 4'b0000;
            tick();
        end
        p_edge  = '0;
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_clr: got ovf=%b, want 0", overflow);
        end
        p_edge  = 4'b0001;
        ovf_clr = 1'b1;
        tick();
        p_edge  = '0;
        ovf_clr = 1'b0;
        vectors++;
        if (overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_drop_wins: got ovf=%b, want 1", overflow);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr   = 1'b0;
        evt_ready = 1'b1;
        tick();
        vectors++;
        if ({evt_valid, evt_id, evt_type, overflow} !== 6'b1_00_00_0) begin
            miscompares++;
            $display("FAIL bp_drain: got v=%b id=%0d t=%b ovf=%b, want v=1 id=0 t=00 ovf=0", evt_valid, evt_id, evt_type, overflow);
        end
        tick();
        vectors++;
        if ({evt_valid, pending_any} !== 2'b00) begin
            miscompares++;
            $display("FAIL bp_empty: got v=%b pend=%b, want 0 0", evt_valid, pending_any);
        end
    endtask

    task automatic test_ordering;
        apply_reset();
        evt_ready = 1'b0;
        p_edge    = 4'b0001;
        tick();
        p_edge = 4'b0010;
        tick();
        p_edge = '0;
        tick();
        tick();
        n_edge = 4'b0010;
        tick();
        n_edge = '0;
        vectors++;
        if ({evt_valid, evt_id, evt_type, pending_any} !== 6'b1_00_00_1) begin
            miscompares++;
            $display("FAIL ord_hold: got v=%b id=%0d t=%b pend=%b, want v=1 id=0 t=00 pend=1", evt_valid, evt_id, evt_type, pending_any);
        end
        evt_ready = 1'b1;
        tick();
        vectors++;
        if ({evt_valid, evt_id, evt_type} !== 5'b1_01_00) begin
            miscompares++;
            $display("FAIL ord_press: got v=%b id=%0d t=%b, want v=1 id=1 t=00", evt_valid, evt_id, evt_type);
        end
        tick();
        vectors++;
        if ({evt_valid, evt_id, evt_type} !== 5'b1_01_01) begin
            miscompares++;
            $display("FAIL ord_release: got v=%b id=%0d t=%b, want v=1 id=1 t=01", evt_valid, evt_id, evt_type);
        end
        tick();
        vectors++;
        if (evt_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL ord_idle: got v=%b, want 0", evt_valid);
        end
    endtask

    task automatic test_reset_mid;
        apply_reset();
        evt_ready = 1'b0;
        p_edge    = 4'b0110;
        tick();
        p_edge = '0;
        tick();
        vectors++;
        if ({evt_valid, evt_id, pending_any} !== 4'b1_01_1) begin
            miscompares++;
            $display("FAIL rmid_pre: got v=%b id=%0d pend=%b, want v=1 id=1 pend=1", evt_valid, evt_id, pending_any);
        end
        rst       = 1'b1;
        p_edge    = 4'b1000;
        evt_ready = 1'b1;
        tick();
        rst    = 1'b0;
        p_edge = '0;
        vectors++;
        if ({evt_valid, evt_id, evt_type, pending_any} !== 6'b0_00_00_0) begin
            miscompares++;
            $display("FAIL rmid_post: got v=%b id=%0d t=%b pend=%b, want v=0 id=0 t=00 pend=0", evt_valid, evt_id, evt_type, pending_any);
        end
        p_edge = 4'b1001;
        tick();
        p_edge = '0;
        tick();
        vectors++;
        if ({evt_valid, evt_id} !== 3'b1_00) begin
            miscompares++;
            $display("FAIL rmid_first: got v=%b id=%0d, want v=1 id=0", evt_valid, evt_id);
        end
        tick();
        vectors++;
        if ({evt_valid, evt_id} !== 3'b1_11) begin
            miscompares++;
            $display("FAIL rmid_second: got v=%b id=%0d, want v=1 id=3", evt_valid, evt_id);
        end
    endtask

    task automatic test_long_press;
        int long_cnt;
        apply_reset();
        evt_ready = 1'b1;
        long_cnt  = 0;
        debounced = 4'b1000;
        for (int i = 0; i < 29; i++) begin
            if (i == 25) debounced = '0;
            tick();
            if (evt_valid === 1'b1 && evt_type === 2'b10 && evt_id === 2'd3) long_cnt++;
        end
        vectors++;
        if (long_cnt !== EXP_LONG_25) begin
            miscompares++;
            $display("FAIL long_25: got %0d long events, want %0d", long_cnt, EXP_LONG_25);
        end
        long_cnt  = 0;
        debounced = 4'b1000;
        for (int i = 0; i < 23; i++) begin
            if (i == 19) debounced = '0;
            tick();
            if (evt_valid === 1'b1 && evt_type === 2'b10) long_cnt++;
        end
        vectors++;
        if (long_cnt !== 0) begin
            miscompares++;
            $display("FAIL long_19: got %0d long events, want 0", long_cnt);
        end
    endtask

    initial begin
        rst       = 1'b1;
        p_edge    = '0;
        n_edge    = '0;
        debounced = '0;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        test_reset();
        test_single_press();
        test_round_robin();
        test_back_to_back();
        test_backpressure();
        test_ordering();
        test_reset_mid();
        test_long_press();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
